// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and sizing helpers for the programmable FIFO.
//   fifo_mode_e - read-side behaviour: FIFO_STD (registered read data) or
//                 FIFO_FWFT (head word presented without a read)
//   ptr_width() - pointer width for a given depth
//   cnt_width() - width of occupancy count and thresholds (holds 0..DEPTH)
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so the count can represent DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_prog_mem.sv
// fifo_prog_mem: DEPTH x DATA_W storage, one synchronous write port and one
// asynchronous (combinational) read port.
//   clk   - write clock, rising edge
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data, combinational from raddr
module fifo_prog_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; contents are only meaningful
  // between the pointers, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_prog.sv
// fifo_prog: parametrised synchronous FIFO with programmable almost-full /
// almost-empty thresholds, optional first-word-fall-through, occupancy count
// and sticky error flags.
//   clk, rst             - clock (rising edge), synchronous active-high reset
//   wr_en, din           - write request and data
//   rd_en                - read request (FWFT: pop head)
//   dout, valid          - read data and its qualifier
//   wr_ack               - pulse: previous-cycle write accepted
//   overflow/underflow   - pulse: previous-cycle write/read rejected
//   full, empty          - occupancy == DEPTH / == 0
//   almostfull/-empty    - threshold flags, combinational from count
//   count                - current occupancy
//   af_thresh, ae_thresh - almost-full / almost-empty levels (0 or >= DEPTH
//                          disables the flag)
//   err_clr              - clears sticky flags (a new error wins)
//   ovf_sticky/udf_sticky- latched overflow / underflow
module fifo_prog
  import fifo_pkg::*;
#(
  parameter int         DATA_W = 16,
  parameter int         DEPTH  = 8,
  parameter fifo_mode_e MODE   = FIFO_STD,
  parameter int         CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              wr_ack,
  output logic              overflow,
  output logic              underflow,
  output logic              full,
  output logic              empty,
  output logic              almostfull,
  output logic              almostempty,
  output logic [CNT_W-1:0]  count,
  input  logic [CNT_W-1:0]  af_thresh,
  input  logic [CNT_W-1:0]  ae_thresh,
  input  logic              err_clr,
  output logic              ovf_sticky,
  output logic              udf_sticky
);

  localparam int             PTR_W   = ptr_width(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] rdata;
  logic              wr_acc;
  logic              rd_acc;
  logic              af_en;
  logic              ae_en;

  // Acceptance is decided on the registered state at the start of the cycle,
  // so a full FIFO rejects a write even when a read frees a slot this cycle.
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Thresholds are live inputs: a new level shows up in the same cycle.
  assign af_en       = (af_thresh != '0) && (af_thresh < DEPTH_C);
  assign ae_en       = (ae_thresh != '0) && (ae_thresh < DEPTH_C);
  assign almostfull  = af_en && (count >= af_thresh) && !full;
  assign almostempty = ae_en && (count <= ae_thresh) && !empty;

  fifo_prog_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wr_ack     <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer overflow is the wrap.
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;

      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      wr_ack    <= wr_acc;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;

      // Sticky flags rise together with their pulse; a new error beats err_clr.
      ovf_sticky <= (wr_en && full)  || (ovf_sticky && !err_clr);
      udf_sticky <= (rd_en && empty) || (udf_sticky && !err_clr);
    end
  end

  generate
    if (MODE == FIFO_STD) begin : g_std
      logic [DATA_W-1:0] dout_q;
      logic              valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) dout_q <= rdata;
        end
      end

      assign dout  = dout_q;
      assign valid = valid_q;
    end else begin : g_fwft
      // Head word is always on the bus; valid just reflects occupancy.
      assign dout  = rdata;
      assign valid = !empty;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_prog.sv
// tb_fifo_prog: drives one STD-mode and one FWFT-mode fifo_prog with the same
// stimulus and checks both against a queue-based model every cycle, plus
// directed literal expectations at the interesting points.
module tb_fifo_prog;
  import fifo_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = cnt_width(DEPTH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic [CNT_W-1:0]  af_thresh = CNT_W'(7);
  logic [CNT_W-1:0]  ae_thresh = CNT_W'(1);
  logic              err_clr = 1'b0;

  logic [DATA_W-1:0] s_dout, f_dout;
  logic              s_valid, f_valid, s_wr_ack, f_wr_ack, s_ovf, f_ovf;
  logic              s_udf, f_udf, s_full, f_full, s_empty, f_empty;
  logic              s_af, f_af, s_ae, f_ae, s_ovs, f_ovs, s_uds, f_uds;
  logic [CNT_W-1:0]  s_count, f_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_prog #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MODE(FIFO_STD)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(s_dout), .valid(s_valid), .wr_ack(s_wr_ack), .overflow(s_ovf),
    .underflow(s_udf), .full(s_full), .empty(s_empty), .almostfull(s_af),
    .almostempty(s_ae), .count(s_count), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .err_clr(err_clr), .ovf_sticky(s_ovs),
    .udf_sticky(s_uds)
  );

  fifo_prog #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MODE(FIFO_FWFT)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(f_dout), .valid(f_valid), .wr_ack(f_wr_ack), .overflow(f_ovf),
    .underflow(f_udf), .full(f_full), .empty(f_empty), .almostfull(f_af),
    .almostempty(f_ae), .count(f_count), .af_thresh(af_thresh),
    .ae_thresh(ae_thresh), .err_clr(err_clr), .ovf_sticky(f_ovs),
    .udf_sticky(f_uds)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] q[$];
  logic              m_wr_ack, m_ovf, m_udf, m_ovs, m_uds, m_valid;
  logic [DATA_W-1:0] m_dout;

  function automatic logic m_af(input int n);
    return (af_thresh >= 1) && (af_thresh < DEPTH) && (n >= af_thresh) && (n != DEPTH);
  endfunction

  function automatic logic m_ae(input int n);
    return (ae_thresh >= 1) && (ae_thresh < DEPTH) && (n <= ae_thresh) && (n != 0);
  endfunction

  always @(posedge clk) begin
    int  n;
    logic wa, ra;
    if (rst) begin
      q.delete();
      m_wr_ack = 0; m_ovf = 0; m_udf = 0; m_ovs = 0; m_uds = 0;
      m_valid = 0; m_dout = '0;
    end else begin
      n  = q.size();
      wa = wr_en && (n != DEPTH);
      ra = rd_en && (n != 0);
      m_wr_ack = wa;
      m_ovf    = wr_en && (n == DEPTH);
      m_udf    = rd_en && (n == 0);
      m_ovs    = m_ovf || (m_ovs && !err_clr);
      m_uds    = m_udf || (m_uds && !err_clr);
      m_valid  = ra;
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(din);
    end
    #1;
    n = q.size();
    check("std_count",  32'(s_count),  32'(n));
    check("fwft_count", 32'(f_count),  32'(n));
    check("std_full",   32'(s_full),   32'(n == DEPTH));
    check("fwft_full",  32'(f_full),   32'(n == DEPTH));
    check("std_empty",  32'(s_empty),  32'(n == 0));
    check("fwft_empty", 32'(f_empty),  32'(n == 0));
    check("std_af",     32'(s_af),     32'(m_af(n)));
    check("fwft_af",    32'(f_af),     32'(m_af(n)));
    check("std_ae",     32'(s_ae),     32'(m_ae(n)));
    check("fwft_ae",    32'(f_ae),     32'(m_ae(n)));
    check("std_wr_ack", 32'(s_wr_ack), 32'(m_wr_ack));
    check("fwft_wr_ack",32'(f_wr_ack), 32'(m_wr_ack));
    check("std_ovf",    32'(s_ovf),    32'(m_ovf));
    check("fwft_ovf",   32'(f_ovf),    32'(m_ovf));
    check("std_udf",    32'(s_udf),    32'(m_udf));
    check("fwft_udf",   32'(f_udf),    32'(m_udf));
    check("std_ovs",    32'(s_ovs),    32'(m_ovs));
    check("fwft_ovs",   32'(f_ovs),    32'(m_ovs));
    check("std_uds",    32'(s_uds),    32'(m_uds));
    check("fwft_uds",   32'(f_uds),    32'(m_uds));
    check("std_valid",  32'(s_valid),  32'(m_valid));
    check("std_dout",   32'(s_dout),   32'(m_dout));
    check("fwft_valid", 32'(f_valid),  32'(n != 0));
    if (n != 0) check("fwft_dout", 32'(f_dout), 32'(q[0]));
  end

  // ---------------- directed stimulus ----------------
  // Drive on the falling edge, return 2 time units after the next rising edge.
  task automatic drive(input logic rs, input logic w, input logic [DATA_W-1:0] d,
                       input logic r, input logic c);
    @(negedge clk);
    rst = rs; wr_en = w; din = d; rd_en = r; err_clr = c;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("rst_count", 32'(s_count), 0);
    check("rst_empty", 32'(s_empty), 1);
    check("rst_dout",  32'(s_dout),  0);
    check("rst_valid", 32'(s_valid), 0);

    // Fill 0x0001..0x0008 with af=7, ae=1.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, DATA_W'(i), 1'b0, 1'b0);
      check("fill_wr_ack", 32'(s_wr_ack), 1);
      check("fill_count",  32'(s_count),  32'(i));
      if (i == 1) check("fill_ae_at1", 32'(s_ae), 1);
      if (i == 2) check("fill_ae_at2", 32'(s_ae), 0);
      if (i == 7) check("fill_af_at7", 32'(s_af), 1);
      if (i == 8) begin
        check("fill_full_at8", 32'(s_full), 1);
        check("fill_af_at8",   32'(s_af),   0);
      end
    end
    check("fwft_head", 32'(f_dout), 32'h0001);

    // 9th write against full.
    drive(1'b0, 1'b1, 16'h0009, 1'b0, 1'b0);
    check("ovf_pulse",  32'(s_ovf),    1);
    check("ovf_ack",    32'(s_wr_ack), 0);
    check("ovf_sticky", 32'(s_ovs),    1);
    check("ovf_count",  32'(s_count),  8);

    // Full FIFO, write and read together.
    drive(1'b0, 1'b1, 16'h000A, 1'b1, 1'b0);
    check("fr_ovf",   32'(s_ovf),   1);
    check("fr_dout",  32'(s_dout),  32'h0001);
    check("fr_valid", 32'(s_valid), 1);
    check("fr_count", 32'(s_count), 7);
    check("fr_fwft",  32'(f_dout),  32'h0002);

    // Drain remaining 7 words.
    for (int i = 2; i <= 8; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
      check("drain_dout", 32'(s_dout), 32'(i));
    end
    check("drain_empty", 32'(s_empty), 1);

    // Underflow and sticky set-wins-over-clear.
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("udf_pulse",  32'(s_udf), 1);
    check("udf_sticky", 32'(s_uds), 1);
    idle();
    check("udf_single", 32'(s_udf), 0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check("udf_set_wins", 32'(s_uds), 1);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("udf_cleared", 32'(s_uds), 0);
    check("ovf_cleared", 32'(s_ovs), 0);
    idle();

    // FWFT: first word visible without a read.
    drive(1'b0, 1'b1, 16'hABCD, 1'b0, 1'b0);
    check("fwft_valid_lit", 32'(f_valid), 1);
    check("fwft_dout_lit",  32'(f_dout),  32'hABCD);
    check("std_no_valid",   32'(s_valid), 0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("fwft_pop_empty", 32'(f_empty), 1);
    check("fwft_pop_valid", 32'(f_valid), 0);
    check("std_pop_dout",   32'(s_dout),  32'hABCD);

    // Wrap: prime 3 words, then 20 simultaneous write/read pairs.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, DATA_W'(16'h0100 + i), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b1, DATA_W'(16'h0103 + k), 1'b1, 1'b0);
      check("wrap_dout",  32'(s_dout),  32'(16'h0100 + k));
      check("wrap_count", 32'(s_count), 3);
    end

    // Threshold changes take effect within the cycle.
    check("af7_at3", 32'(s_af), 0);
    af_thresh = CNT_W'(3);
    #1 check("af3_at3", 32'(s_af), 1);
    af_thresh = CNT_W'(0);
    #1 check("af0_off", 32'(f_af), 0);
    ae_thresh = CNT_W'(3);
    #1 check("ae3_at3", 32'(s_ae), 1);
    ae_thresh = CNT_W'(8);
    #1 check("ae8_off", 32'(s_ae), 0);
    af_thresh = CNT_W'(7);
    ae_thresh = CNT_W'(1);

    // Reset mid-operation at count 5 with a write pending.
    drive(1'b0, 1'b1, 16'h0200, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0201, 1'b0, 1'b0);
    check("pre_rst_count", 32'(s_count), 5);
    drive(1'b1, 1'b1, 16'h0055, 1'b0, 1'b0);
    check("rst_mid_count", 32'(s_count),  0);
    check("rst_mid_empty", 32'(s_empty),  1);
    check("rst_mid_ack",   32'(s_wr_ack), 0);
    check("rst_mid_ovf",   32'(s_ovf),    0);
    check("rst_mid_udf",   32'(s_udf),    0);
    check("rst_mid_dout",  32'(s_dout),   0);
    idle();
    check("post_rst_ack",   32'(f_wr_ack), 0);
    check("post_rst_count", 32'(f_count),  0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fifo_prog.md
Name: fifo_prog

Overview:
Parametrised synchronous FIFO, successor to the fixed-size FIFO in the SPI/RAM/FIFO subsystem. Width and depth are configurable. Almost-full and almost-empty thresholds are programmable at run time. Adds a first-word-fall-through (FWFT) mode, an occupancy count, and sticky error flags with software clear. Per-cycle handshake flags (wr_ack, overflow, underflow) keep the existing semantics so the current FIFO assertion set carries over.

Parameters:
DATA_W, 16, data width in bits
DEPTH, 8, number of entries; power of 2, minimum 4
MODE, FIFO_STD, fifo_pkg::fifo_mode_e; FIFO_STD = registered read data, FIFO_FWFT = head word presented without a read
CNT_W, $clog2(DEPTH)+1, derived width of count and thresholds; not to be overridden

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  write request
din  in  DATA_W  write data
rd_en  in  1  read request (FWFT: pop head)
dout  out  DATA_W  read data
valid  out  1  dout holds a read word
wr_ack  out  1  previous-cycle write accepted
overflow  out  1  previous-cycle write rejected (FIFO full)
underflow  out  1  previous-cycle read rejected (FIFO empty)
full  out  1  count == DEPTH
empty  out  1  count == 0
almostfull  out  1  occupancy at or above af_thresh, not full
almostempty  out  1  occupancy at or below ae_thresh, not empty
count  out  CNT_W  current occupancy
af_thresh  in  CNT_W  almost-full level
ae_thresh  in  CNT_W  almost-empty level
err_clr  in  1  clears sticky flags
ovf_sticky  out  1  latched overflow
udf_sticky  out  1  latched underflow

Behaviour:
- Acceptance: write accepted iff wr_en && !full; read accepted iff rd_en && !empty. Both are evaluated on the registered state at the start of the cycle.
- Simultaneous write and read:
  - Both accepted when neither full nor empty; count unchanged.
  - When full, the read is accepted and the write rejected (overflow).
  - When empty, the write is accepted and the read rejected (underflow).
- Pointers: width $clog2(DEPTH); increment on accept; wrap DEPTH-1 -> 0.
- count: +1 on write-only, -1 on read-only; never exceeds DEPTH or drops below 0.
- Status flags: full, empty, almostfull, almostempty are combinational from registered count and current thresholds. A threshold change takes effect in the same cycle.
  - almostfull = (count >= af_thresh) && !full. af_thresh of 0 or >= DEPTH disables it (held 0).
  - almostempty = (count <= ae_thresh) && !empty. ae_thresh of 0 or >= DEPTH disables it.
- Handshake flags: wr_ack, overflow, underflow are registered single-cycle pulses, one cycle after the request. They assert on every rejected request, including back-to-back ones; overflow stays high for as long as wr_en is held against a full FIFO.
- FIFO_STD mode: dout is updated one cycle after an accepted read; valid pulses with it. dout holds its last value otherwise.
- FIFO_FWFT mode:
  - dout = mem[rd_ptr] and valid = !empty, both combinational from registered state.
  - rd_en pops the head.
  - The first write into an empty FIFO is visible on dout the cycle after the write.
- Sticky flags: ovf_sticky is set when overflow asserts; udf_sticky likewise. err_clr clears both. Set wins over a simultaneous clear.
- Reset values (asserted on the edge where rst=1): pointers 0, count 0, empty 1, full 0, almostfull 0, almostempty 0, dout 0, valid 0, wr_ack 0, overflow 0, underflow 0, both sticky flags 0.
- Reset mid-operation: contents discarded (memory not cleared); wr_en and rd_en in the reset cycle are ignored and produce no ack or error pulse.
- Memory: write is synchronous; read address is combinational from rd_ptr.

Decomposition:
- fifo_pkg holds:
  - typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT};
  - function clog2-based width helper;
  - shared by fifo_prog and the bench.
- One sub-module, fifo_prog_mem: DEPTH x DATA_W dual-port storage with synchronous write port and asynchronous read port.
- Pointer, count, flag and mode logic stay in fifo_prog.

Test Plan (DEPTH=8, DATA_W=16):
- Reset, then write 0x0001..0x0008 back-to-back with af_thresh=7, ae_thresh=1 -> wr_ack each cycle after a write; almostempty at count 1; almostfull at count 7; full at count 8 and almostfull falls with it. A 9th write -> overflow=1 the next cycle, ovf_sticky=1, count stays 8.
- Full FIFO, wr_en and rd_en together -> read accepted, write rejected, overflow=1. STD mode: dout=0x0001 and valid next cycle. count=7.
- Empty FIFO, rd_en -> underflow=1 for one cycle and udf_sticky=1. Then assert err_clr and rd_en in the same cycle -> udf_sticky stays 1 (set wins). err_clr alone -> 0.
- FWFT mode: write 0xABCD into an empty FIFO -> next cycle valid=1, dout=0xABCD with no rd_en; rd_en pops; empty=1 the following cycle.
- Wrap and thresholds:
  - 20 interleaved write/read pairs at count 3 -> data order preserved across pointer wrap; count constant at 3.
  - Change af_thresh from 7 to 3 mid-run -> almostfull=1 the same cycle.
  - Set af_thresh=0 -> almostfull=0.
- Assert rst with count=5 while wr_en=1 -> the next cycle has count 0, empty 1, and all pulses 0; no wr_ack is generated.
